// File: rtl/priority_encoder.sv
// Registered find-first-set encoder: lowest set bit of `in` wins, `none` flags an empty vector.
// Built as a log2-depth pairwise reduction tree over the input padded to a power of two.
module priority_encoder #(
   parameter  int unsigned WIDTH = 256,
   localparam int unsigned OUT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] in,
   output logic [OUT_W-1:0] out,
   output logic             none
);

   localparam int unsigned LEVELS = $clog2(WIDTH);
   localparam int unsigned PAD_W  = 1 << LEVELS;

   logic             any_c;
   logic [OUT_W-1:0] idx_c;

   // Reduce in place: level l node n combines level l-1 nodes 2n and 2n+1, lower index wins.
   always_comb begin : tree
      logic             node_any [PAD_W];
      logic [OUT_W-1:0] node_idx [PAD_W];
      logic [PAD_W-1:0] pad;

      pad = PAD_W'(in);
      for (int n = 0; n < PAD_W; n++) begin
         node_any[n] = pad[n];
         node_idx[n] = OUT_W'(n);
      end
      for (int l = 1; l <= LEVELS; l++) begin
         for (int n = 0; n < (PAD_W >> l); n++) begin
            if (node_any[2*n]) begin
               node_idx[n] = node_idx[2*n];
            end else if (node_any[2*n+1]) begin
               node_idx[n] = node_idx[2*n+1];
            end else begin
               node_idx[n] = '0;
            end
            node_any[n] = node_any[2*n] | node_any[2*n+1];
         end
      end
      any_c = node_any[0];
      idx_c = node_idx[0];
   end

   // Output register; an empty vector yields index 0 with none set.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         out  <= '0;
         none <= 1'b1;
      end else begin
         out  <= idx_c;
         none <= ~any_c;
      end
   end

endmodule

// File: tb/tb_priority_encoder.sv
// Self-checking bench for priority_encoder at WIDTH=256 and WIDTH=5 against a scan-based reference.
module tb_priority_encoder;

   logic         clk;
   logic         rst;
   logic [255:0] din;
   logic [7:0]   dout;
   logic         dnone;
   logic [4:0]   din5;
   logic [2:0]   dout5;
   logic         dnone5;

   int n_cmp;
   int n_bad;

   priority_encoder #(.WIDTH(256)) dut (
      .CLK(clk), .RST(rst), .in(din), .out(dout), .none(dnone)
   );

   priority_encoder #(.WIDTH(5)) dut5 (
      .CLK(clk), .RST(rst), .in(din5), .out(dout5), .none(dnone5)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: first set bit by plain scan of the low w bits.
   function automatic void ref_enc(input logic [255:0] v, input int w,
                                   output int idx, output bit nil);
      nil = 1'b1;
      idx = 0;
      for (int i = 0; i < w; i++) begin
         if (v[i] && nil) begin
            idx = i;
            nil = 1'b0;
         end
      end
   endfunction

   task automatic step(input logic [255:0] v, input logic [4:0] v5, input string tag);
      int idx;
      bit nil;
      din  = v;
      din5 = v5;
      @(posedge clk);
      #1;
      ref_enc(v, 256, idx, nil);
      check({tag, ".out"},  32'(dout),  32'(idx));
      check({tag, ".none"}, 32'(dnone), 32'(nil));
      ref_enc(256'(v5), 5, idx, nil);
      check({tag, ".out5"},  32'(dout5),  32'(idx));
      check({tag, ".none5"}, 32'(dnone5), 32'(nil));
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, ".out"},   32'(dout),   32'd0);
      check({tag, ".none"},  32'(dnone),  32'd1);
      check({tag, ".out5"},  32'(dout5),  32'd0);
      check({tag, ".none5"}, 32'(dnone5), 32'd1);
   endtask

   initial begin
      logic [255:0] v;
      logic [4:0]   v5;
      n_cmp = 0;
      n_bad = 0;
      clk   = 1'b0;
      rst   = 1'b1;
      din   = '1;
      din5  = '1;

      // Reset held with all-ones input
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rel.out",   32'(dout),   32'd0);
      check("rel.none",  32'(dnone),  32'd0);
      check("rel.out5",  32'(dout5),  32'd0);
      check("rel.none5", 32'(dnone5), 32'd0);

      // One-hot sweep
      for (int k = 0; k < 256; k++) begin
         v = '0;
         v[k] = 1'b1;
         v5 = 5'b00001 << (k % 5);
         step(v, v5, $sformatf("onehot%0d", k));
      end

      // Priority among several set bits
      v = '0; v[255] = 1'b1; v[130] = 1'b1; v[7] = 1'b1;
      step(v, 5'b10000, "prio_7");
      v = '0; v[255] = 1'b1; v[128] = 1'b1;
      step(v, 5'b01010, "prio_128");
      v = '0; v[255] = 1'b1;
      step(v, 5'b11000, "prio_255");

      // Empty then full
      step('0, 5'b00000, "empty");
      step('1, 5'b11111, "full");

      // Randomized, with sparse/high/empty mixes and a mid-stream reset
      for (int i = 0; i < 10000; i++) begin
         if (i == 5000) begin
            rst = 1'b1;
            #1;
            check_reset_state("midrst_async");
            @(posedge clk);
            #1;
            check_reset_state("midrst_hold");
            rst = 1'b0;
         end
         case ($urandom_range(0, 3))
            0: for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom;
            1: begin
               v = '0;
               repeat ($urandom_range(1, 3)) v[$urandom_range(0, 255)] = 1'b1;
            end
            2: begin
               v = '0;
               v[$urandom_range(200, 255)] = 1'b1;
               if ($urandom_range(0, 1) == 1) v[$urandom_range(0, 255)] = 1'b1;
            end
            default: v = ($urandom_range(0, 3) == 0) ? '0 : {8{$urandom}} & {8{$urandom}};
         endcase
         v5 = 5'($urandom);
         if ($urandom_range(0, 7) == 0) v5 = '0;
         step(v, v5, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
